sram_arbiter_2m: RTL and testbench

- Shares the single-port, byte-enabled on-chip SRAM (sram0, 32-bit words) between two requesters: M0 is the CPU data port and M1 is the DMA/debug loader.
- Arbitration is round-robin. A requester may lock the SRAM for a bounded burst; a burst limit prevents starvation.
- One SRAM access is issued per cycle. The SRAM has a synchronous read with 1-cycle latency, and read data is routed back to the requester that issued the read.

---
 rtl/sram_arbiter_2m.sv | 141 ++++++++++++++
 tb/tb_sram_arbiter_2m.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_2m.sv
// Two-master round-robin arbiter for a single-port byte-enabled SRAM; grant and SRAM drive are combinational (0-cycle), read data returns 1 cycle after grant.
// Losing requester is back-pressured by holding gnt low; it must keep its request stable until granted.
module sram_arbiter_2m #(
    parameter int W_ADDR    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_write,
    input  logic [W_ADDR-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_bytemask,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_write,
    input  logic [W_ADDR-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_bytemask,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [W_ADDR-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_bytemask,
    input  logic [31:0]       sram_rdata
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

    logic       last_gnt_q, last_gnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;

    logic owner_req;
    logic owner_lock;
    logic locked;
    logic gnt0;
    logic gnt1;
    logic xfer_lock;
    logic xfer_write;

    // The owner keeps the SRAM only while it still asks, asks for lock, and is under the burst limit.
    always_comb begin
        owner_req  = last_gnt_q ? m1_req  : m0_req;
        owner_lock = last_gnt_q ? m1_lock : m0_lock;
        locked     = owner_req && owner_lock && (burst_cnt_q < BURST_LIM);
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (locked ? last_gnt_q : !last_gnt_q) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sram_en       = 1'b0;
        sram_wen      = 1'b0;
        sram_addr     = '0;
        sram_wdata    = '0;
        sram_bytemask = '0;
        xfer_lock     = 1'b0;
        xfer_write    = 1'b0;
        if (gnt0) begin
            sram_en       = 1'b1;
            sram_wen      = m0_write;
            sram_addr     = m0_addr;
            sram_wdata    = m0_wdata;
            sram_bytemask = m0_write ? m0_bytemask : 4'hf;
            xfer_lock     = m0_lock;
            xfer_write    = m0_write;
        end else if (gnt1) begin
            sram_en       = 1'b1;
            sram_wen      = m1_write;
            sram_addr     = m1_addr;
            sram_wdata    = m1_wdata;
            sram_bytemask = m1_write ? m1_bytemask : 4'hf;
            xfer_lock     = m1_lock;
            xfer_write    = m1_write;
        end
    end

    always_comb begin
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        rd_pend_d   = 1'b0;
        rd_owner_d  = rd_owner_q;
        if (gnt0 || gnt1) begin
            last_gnt_d = gnt1;
            if ((gnt1 == last_gnt_q) && xfer_lock) begin
                burst_cnt_d = (burst_cnt_q == 8'hff) ? 8'hff : burst_cnt_q + 8'd1;
            end else begin
                burst_cnt_d = '0;
            end
            if (!xfer_write) begin
                rd_pend_d  = 1'b1;
                rd_owner_d = gnt1;
            end
        end else if (!(owner_req && owner_lock)) begin
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rst_n && rd_pend_q && !rd_owner_q;
    assign m1_rvalid = rst_n && rd_pend_q && rd_owner_q;
    assign m0_rdata  = m0_rvalid ? sram_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_arbiter_2m.sv
// Bench for sram_arbiter_2m: behavioural SRAM, per-requester read scoreboards, directed arbitration scenarios.
module tb_sram_arbiter_2m;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_lock, m0_write;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_bytemask;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_lock, m1_write;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_bytemask;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        sram_en, sram_wen;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_bytemask;
    logic [31:0] sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:255];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    sram_arbiter_2m #(.W_ADDR(16), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_bytemask(m0_bytemask), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_bytemask(m1_bytemask), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_bytemask(sram_bytemask), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'h5A000000 + 32'(i) * 32'h00000101;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] bm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (bm[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Synchronous-read SRAM driven only from the arbiter's sram_* outputs.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_bytemask[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= sram_mem[sram_addr[7:0]];
            end
        end
    end

    // Scoreboard: predictions come from requester-side inputs and a reference memory.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            chk("one_gnt", {31'b0, m0_gnt & m1_gnt}, 32'h0);
            if (m0_rvalid) begin
                if (q0.size() == 0) chk("m0_spurious_rvalid", 32'h1, 32'h0);
                else chk("m0_rdata_sb", m0_rdata, q0.pop_front());
            end
            if (m1_rvalid) begin
                if (q1.size() == 0) chk("m1_spurious_rvalid", 32'h1, 32'h0);
                else chk("m1_rdata_sb", m1_rdata, q1.pop_front());
            end
            if (m0_req && m0_gnt) begin
                if (m0_write) ref_mem[m0_addr[7:0]] = merge(ref_mem[m0_addr[7:0]], m0_wdata, m0_bytemask);
                else q0.push_back(ref_mem[m0_addr[7:0]]);
            end
            if (m1_req && m1_gnt) begin
                if (m1_write) ref_mem[m1_addr[7:0]] = merge(ref_mem[m1_addr[7:0]], m1_wdata, m1_bytemask);
                else q1.push_back(ref_mem[m1_addr[7:0]]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(logic req, logic lock, logic wr, logic [15:0] a, logic [31:0] d, logic [3:0] bm);
        m0_req = req; m0_lock = lock; m0_write = wr; m0_addr = a; m0_wdata = d; m0_bytemask = bm;
    endtask

    task automatic drv1(logic req, logic lock, logic wr, logic [15:0] a, logic [31:0] d, logic [3:0] bm);
        m1_req = req; m1_lock = lock; m1_write = wr; m1_addr = a; m1_wdata = d; m1_bytemask = bm;
    endtask

    initial begin
        rst_n = 1'b0;
        sram_rdata = 32'h0;
        drv0(0, 0, 0, 16'h0, 32'h0, 4'h0);
        drv1(0, 0, 0, 16'h0, 32'h0, 4'h0);
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        sram_mem[4] = 32'h11223344;
        ref_mem[4]  = 32'h11223344;

        repeat (2) cyc();
        @(negedge clk);
        chk("rst_sram_en", {31'b0, sram_en}, 32'h0);
        chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
        cyc();
        rst_n = 1'b1;

        // First contention after reset goes to M0.
        drv0(1, 0, 0, 16'h10, 32'h0, 4'h0);
        drv1(1, 0, 0, 16'h20, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_m0_gnt", {31'b0, m0_gnt}, 32'h1);
        chk("t1_m1_gnt", {31'b0, m1_gnt}, 32'h0);
        chk("t1_addr", 32'(sram_addr), 32'h10);
        cyc();
        drv0(0, 0, 0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_m1_gnt2", {31'b0, m1_gnt}, 32'h1);
        chk("t1_addr2", 32'(sram_addr), 32'h20);
        chk("t1_m0_rvalid", {31'b0, m0_rvalid}, 32'h1);
        chk("t1_m0_rdata", m0_rdata, init_word(16'h10));
        cyc();
        drv1(0, 0, 0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'h1);
        chk("t1_m1_rdata", m1_rdata, init_word(16'h20));
        cyc();

        // Unlocked contention alternates, starting with M0.
        drv0(1, 0, 0, 16'h1, 32'h0, 4'h0);
        drv1(1, 0, 0, 16'h2, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t2_m0_gnt", {31'b0, m0_gnt}, {31'b0, (k % 2) == 0});
            chk("t2_m1_gnt", {31'b0, m1_gnt}, {31'b0, (k % 2) == 1});
            cyc();
        end
        drv0(0, 0, 0, 16'h0, 32'h0, 4'h0);
        drv1(0, 0, 0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        cyc();

        // Byte-masked write followed by a read of the same word.
        drv1(1, 0, 1, 16'h4, 32'hDEADBEEF, 4'b0101);
        @(negedge clk);
        chk("t3_wr_gnt", {31'b0, m1_gnt}, 32'h1);
        chk("t3_wen", {31'b0, sram_wen}, 32'h1);
        chk("t3_wr_bm", {28'b0, sram_bytemask}, 32'h5);
        chk("t3_wdata", sram_wdata, 32'hDEADBEEF);
        cyc();
        drv1(0, 0, 0, 16'h0, 32'h0, 4'h0);
        drv0(1, 0, 0, 16'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("t3_rd_gnt", {31'b0, m0_gnt}, 32'h1);
        chk("t3_rd_bm", {28'b0, sram_bytemask}, 32'hf);
        chk("t3_rd_wen", {31'b0, sram_wen}, 32'h0);
        cyc();
        drv0(0, 0, 0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t3_rdata", m0_rdata, 32'h11AD33EF);
        cyc();

        // Make M1 the last owner so M0 starts its burst by winning contention.
        drv1(1, 0, 0, 16'h9, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4_pre_gnt", {31'b0, m1_gnt}, 32'h1);
        cyc();
        drv0(1, 1, 0, 16'h8, 32'h0, 4'h0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("t4_burst_m0", {31'b0, m0_gnt}, {31'b0, k < 8});
            chk("t4_burst_m1", {31'b0, m1_gnt}, {31'b0, k == 8});
            cyc();
        end
        drv0(0, 0, 0, 16'h0, 32'h0, 4'h0);
        drv1(0, 0, 0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4_burst_cnt", 32'(dut.burst_cnt_q), 32'h0);
        cyc();

        // Back-to-back reads return one per cycle, in order.
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drv0(1, 0, 0, 16'(k), 32'h0, 4'h0);
            else drv0(0, 0, 0, 16'h0, 32'h0, 4'h0);
            @(negedge clk);
            chk("t5_gnt", {31'b0, m0_gnt}, {31'b0, k < 4});
            chk("t5_rvalid", {31'b0, m0_rvalid}, {31'b0, k >= 1});
            if (k >= 1) chk("t5_rdata", m0_rdata, init_word(k - 1));
            cyc();
        end

        // Reset in the cycle after a read grant drops the pending return.
        drv0(1, 0, 0, 16'h5, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_gnt", {31'b0, m0_gnt}, 32'h1);
        cyc();
        rst_n = 1'b0;
        drv0(1, 0, 0, 16'h6, 32'h0, 4'h0);
        drv1(1, 0, 0, 16'h7, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_rvalid", {31'b0, m0_rvalid}, 32'h0);
        chk("t6_m0_gnt", {31'b0, m0_gnt}, 32'h0);
        chk("t6_m1_gnt", {31'b0, m1_gnt}, 32'h0);
        chk("t6_sram_en", {31'b0, sram_en}, 32'h0);
        chk("t6_sram_addr", 32'(sram_addr), 32'h0);
        chk("t6_sram_bm", {28'b0, sram_bytemask}, 32'h0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_m0", {31'b0, m0_gnt}, 32'h1);
        chk("t6_post_m1", {31'b0, m1_gnt}, 32'h0);
        chk("t6_post_addr", 32'(sram_addr), 32'h6);
        cyc();
        drv0(0, 0, 0, 16'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_post_m1b", {31'b0, m1_gnt}, 32'h1);
        cyc();
        drv1(0, 0, 0, 16'h0, 32'h0, 4'h0);
        repeat (2) cyc();
        @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
